rr_pcim_wr_arbiter: RTL and testbench
=====================================

RR_PCIM_WR_ARBITER -- requirements
Module: rr_pcim_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of write requesters (2..16).
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 64: pcim address width.
REQ-003 SHALL have parameter AXI_WIDTH, default 512: pcim data width; one beat per write.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 8: maximum writes awaiting B (1..32).
REQ-005 SHALL have ports clk (in, 1) and rst (in, 1); one clock; reset is synchronous and active-high.
REQ-006 SHALL have req_valid (in, NUM_REQ): per-requester write request.
REQ-007 SHALL have req_addr (in, NUM_REQ*AXI_ADDR_WIDTH) and req_data (in, NUM_REQ*AXI_WIDTH): slice i belongs to requester i.
REQ-008 SHALL have req_ready (out, NUM_REQ): one-hot, one-cycle acceptance pulse.
REQ-009 SHALL have req_done (out, NUM_REQ) and req_err (out, NUM_REQ): one-cycle pulse on B return to requester bid; req_err set when bresp != 0.
REQ-010 SHALL have pcim write ports: awvalid/awaddr/awid[15:0]/awlen[7:0]/awsize[2:0] (out), awready (in), wvalid/wdata/wstrb/wlast (out), wready (in), bvalid/bid[15:0]/bresp[1:0] (in), bready (out).
REQ-011 SHALL have perf_wr_cnt (out, 32) and perf_full_cnt (out, 32).

Function
REQ-012 SHALL implement states ARB_IDLE and ARB_ISSUE; ARB_IDLE->ARB_ISSUE on grant, ARB_ISSUE->ARB_IDLE once both AW and W handshakes completed.
REQ-013 SHALL grant in ARB_IDLE when any req_valid is set and outstanding < MAX_OUTSTANDING; priority round-robin starting at (last_grant+1) mod NUM_REQ.
REQ-014 SHALL pulse req_ready[g] in the grant cycle and register req_addr/req_data slice g, setting awid = g.
REQ-015 SHALL assert awvalid and wvalid in the cycle after grant (registered outputs); latency req_valid -> awvalid is 1 cycle minimum.
REQ-016 SHALL hold awvalid until awready and wvalid until wready, independently; either may complete first or both in the same cycle; payload stable while valid.
REQ-017 SHALL drive awlen=0, awsize=3'b110, wstrb all-ones, wlast=1, bready=1.
REQ-018 SHALL increment outstanding when a write's second handshake completes, decrement on bvalid; simultaneous increment and decrement leaves it unchanged.
REQ-019 SHALL not grant while outstanding == MAX_OUTSTANDING (full); grants resume the cycle after a B drops the count.
REQ-020 SHALL accept a B while outstanding == 0 without underflow and without req_done/req_err pulse.
REQ-021 SHALL ignore a B whose bid >= NUM_REQ for pulses but still decrement outstanding.
REQ-022 SHALL update last_grant only on grant; a requester dropping req_valid before grant loses nothing.

Reset
REQ-023 SHALL on rst: state ARB_IDLE, awvalid=wvalid=0, req_ready=req_done=req_err=0, outstanding=0, last_grant=NUM_REQ-1 (so requester 0 wins first), awaddr/wdata/awid=0, perf counters 0.
REQ-024 SHALL abandon any in-flight AW/W on rst mid-ARB_ISSUE; B returns for pre-reset writes fall under REQ-020.

Configuration
REQ-025 SHALL, with RR_PCIM_ARB_PERF_EN defined, count completed writes in perf_wr_cnt and cycles with pending req_valid blocked by full in perf_full_cnt, both wrapping at 2^32.
REQ-026 SHALL, without RR_PCIM_ARB_PERF_EN, tie perf_wr_cnt and perf_full_cnt to 0 and infer no counter logic.

Verification
REQ-027 SHALL cover: req_valid=4'b1111 held, awready=wready=1 -> grants in order 0,1,2,3,0 with awid matching.
REQ-028 SHALL cover: single req 2, addr 0x1000, wready one cycle before awready -> one AW, one W, awaddr 0x1000, state back to ARB_IDLE after AW.
REQ-029 SHALL cover: MAX_OUTSTANDING=2, bvalid held low, 3 requests -> 2 issued, third stalls; bvalid bid=1 -> third granted next cycle.
REQ-030 SHALL cover: bvalid bid=3 bresp=2'b10 -> req_done[3]=req_err[3]=1 for one cycle; bvalid with outstanding=0 -> no pulse, count stays 0.
REQ-031 SHALL cover: rst asserted with awvalid high and awready low -> awvalid 0 next cycle, requester 0 granted first after release.
REQ-032 SHALL cover, with RR_PCIM_ARB_PERF_EN: 5 completed writes and 3 full-stall cycles -> perf_wr_cnt=5, perf_full_cnt=3; without macro both read 0.

Source files
------------

// File: rtl/rr_pcim_wr_arbiter_if.sv
// rtl/rr_pcim_wr_arbiter_if.sv - requester and pcim write-channel bundle for rr_pcim_wr_arbiter
interface rr_pcim_wr_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_WIDTH      = 512
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*AXI_WIDTH-1:0]      req_data;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0]                req_done;
  logic [NUM_REQ-1:0]                req_err;

  logic                      awvalid;
  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic [15:0]               awid;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic                      awready;

  logic                      wvalid;
  logic [AXI_WIDTH-1:0]      wdata;
  logic [AXI_WIDTH/8-1:0]    wstrb;
  logic                      wlast;
  logic                      wready;

  logic                      bvalid;
  logic [15:0]               bid;
  logic [1:0]                bresp;
  logic                      bready;

  // master is the arbiter side: it serves the requesters and drives pcim
  modport master (
    input  req_valid, req_addr, req_data,
    output req_ready, req_done, req_err,
    output awvalid, awaddr, awid, awlen, awsize,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    output req_valid, req_addr, req_data,
    input  req_ready, req_done, req_err,
    input  awvalid, awaddr, awid, awlen, awsize,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/rr_pcim_wr_arbiter.sv
// rtl/rr_pcim_wr_arbiter.sv - round-robin single-beat pcim write arbiter with outstanding-B limit
// Optional perf counters enabled by defining RR_PCIM_ARB_PERF_EN.
module rr_pcim_wr_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int AXI_ADDR_WIDTH  = 64,
  parameter int AXI_WIDTH       = 512,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_pcim_wr_arbiter_if.master bus,
  output logic [31:0]          perf_wr_cnt,
  output logic [31:0]          perf_full_cnt
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {ARB_IDLE, ARB_ISSUE} arb_state_t;

  arb_state_t                r_state;
  logic [IDX_W-1:0]          r_last_grant;
  logic [IDX_W-1:0]          r_awid;
  logic                      r_awvalid;
  logic                      r_wvalid;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [AXI_WIDTH-1:0]      r_wdata;
  logic [OUT_W-1:0]          r_outstanding;
  logic [NUM_REQ-1:0]        r_req_done;
  logic [NUM_REQ-1:0]        r_req_err;

  logic             w_pick_found;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_full;
  logic             w_grant;
  logic             w_wr_complete;
  logic             w_b_accept;
  logic             w_bid_ok;
  logic [IDX_W-1:0] w_bid_idx;

  // First valid requester scanning upward from last_grant+1, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0]   result;
    logic [IDX_W-1:0] idx;
    int               pos;
    result = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(last) + k) % NUM_REQ;
      idx = pos[IDX_W-1:0];
      if (!result[IDX_W] && valid[idx]) begin
        result = {1'b1, idx};
      end
    end
    return result;
  endfunction

  assign {w_pick_found, w_pick_idx} = rr_pick(bus.req_valid, r_last_grant);

  assign w_full  = (r_outstanding >= OUT_W'(MAX_OUTSTANDING));
  assign w_grant = !rst && (r_state == ARB_IDLE) && w_pick_found && !w_full;

  // The write retires once each channel has either already handshaken or does so now.
  assign w_wr_complete = (r_state == ARB_ISSUE) &&
                         (!r_awvalid || bus.awready) &&
                         (!r_wvalid  || bus.wready);

  assign w_b_accept = bus.bvalid && (r_outstanding != '0);
  assign w_bid_ok   = (bus.bid < 16'(NUM_REQ));
  assign w_bid_idx  = bus.bid[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_awid       <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant) begin
            r_state      <= ARB_ISSUE;
            r_last_grant <= w_pick_idx;
            r_awid       <= w_pick_idx;
            r_awaddr     <= bus.req_addr[int'(w_pick_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            r_wdata      <= bus.req_data[int'(w_pick_idx)*AXI_WIDTH +: AXI_WIDTH];
            r_awvalid    <= 1'b1;
            r_wvalid     <= 1'b1;
          end
        end
        ARB_ISSUE: begin
          if (bus.awready) begin
            r_awvalid <= 1'b0;
          end
          if (bus.wready) begin
            r_wvalid <= 1'b0;
          end
          if (w_wr_complete) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // A B with nothing outstanding is absorbed silently so stale pre-reset responses cannot underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
      r_req_done    <= '0;
      r_req_err     <= '0;
    end else begin
      r_req_done <= '0;
      r_req_err  <= '0;
      if (w_b_accept && w_bid_ok) begin
        r_req_done[w_bid_idx] <= 1'b1;
        r_req_err[w_bid_idx]  <= (bus.bresp != 2'b00);
      end
      case ({w_wr_complete, w_b_accept})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign bus.req_ready = w_grant ? (NUM_REQ'(1) << w_pick_idx) : '0;
  assign bus.req_done  = r_req_done;
  assign bus.req_err   = r_req_err;

  assign bus.awvalid = r_awvalid;
  assign bus.awaddr  = r_awaddr;
  assign bus.awid    = 16'(r_awid);
  assign bus.awlen   = 8'h00;
  assign bus.awsize  = 3'b110;
  assign bus.wvalid  = r_wvalid;
  assign bus.wdata   = r_wdata;
  assign bus.wstrb   = '1;
  assign bus.wlast   = 1'b1;
  assign bus.bready  = 1'b1;

`ifdef RR_PCIM_ARB_PERF_EN
  logic [31:0] r_perf_wr_cnt;
  logic [31:0] r_perf_full_cnt;
  logic        w_full_block;

  assign w_full_block = (r_state == ARB_IDLE) && (|bus.req_valid) && w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_wr_cnt   <= '0;
      r_perf_full_cnt <= '0;
    end else begin
      if (w_wr_complete) begin
        r_perf_wr_cnt <= r_perf_wr_cnt + 32'd1;
      end
      if (w_full_block) begin
        r_perf_full_cnt <= r_perf_full_cnt + 32'd1;
      end
    end
  end

  assign perf_wr_cnt   = r_perf_wr_cnt;
  assign perf_full_cnt = r_perf_full_cnt;
`else
  assign perf_wr_cnt   = 32'd0;
  assign perf_full_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_rr_pcim_wr_arbiter.sv
// tb/tb_rr_pcim_wr_arbiter.sv - self-checking bench for rr_pcim_wr_arbiter
module tb_rr_pcim_wr_arbiter;
  localparam int NR   = 4;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int MAXO = 2;

  logic        clk;
  logic        rst;
  logic [31:0] perf_wr_cnt;
  logic [31:0] perf_full_cnt;

  rr_pcim_wr_arbiter_if #(.NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_WIDTH(DW)) bus ();

  rr_pcim_wr_arbiter #(
    .NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.master),
    .perf_wr_cnt(perf_wr_cnt), .perf_full_cnt(perf_full_cnt)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model: the write in flight, the B credit count and the round-robin pointer.
  bit          m_busy, m_aw, m_w;
  int          m_id, m_out, m_last, m_wr, m_full;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [NR-1:0] m_done, m_err;

  logic [NR-1:0] last_ready;
  int            grants[$];
  int            n_aw_hs, n_w_hs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_aw = 0; m_w = 0;
    m_id = 0; m_out = 0; m_last = NR - 1; m_wr = 0; m_full = 0;
    m_addr = '0; m_data = '0; m_done = '0; m_err = '0;
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
    bus.awready = 0; bus.wready = 0;
    bus.bvalid = 0; bus.bid = '0; bus.bresp = '0;
  endtask

  // One clock: check DUT against model at negedge, advance model, return at posedge+1.
  task automatic cycle();
    int            g;
    logic [NR-1:0] exp_ready;
    bit            complete, beff;
    logic [31:0]   exp_pwr, exp_pfull;
    @(negedge clk);
    g = (!rst && !m_busy && m_out < MAXO) ? rr_pick(bus.req_valid, m_last) : -1;
    exp_ready = (g >= 0) ? NR'(1 << g) : '0;
    last_ready = bus.req_ready;
    for (int i = 0; i < NR; i++) if (bus.req_ready[i]) grants.push_back(i);
    if (bus.awvalid && bus.awready) n_aw_hs++;
    if (bus.wvalid && bus.wready) n_w_hs++;
`ifdef RR_PCIM_ARB_PERF_EN
    exp_pwr = m_wr; exp_pfull = m_full;
`else
    exp_pwr = 0; exp_pfull = 0;
`endif
    chk("req_ready", bus.req_ready, exp_ready);
    chk("awvalid", bus.awvalid, m_busy && m_aw);
    chk("wvalid", bus.wvalid, m_busy && m_w);
    if (m_busy) begin
      chk("awid", bus.awid, m_id);
      chk("awaddr", bus.awaddr, m_addr);
      chk("wdata", bus.wdata, m_data);
    end
    chk("req_done", bus.req_done, m_done);
    chk("req_err", bus.req_err, m_err);
    chk("perf_wr_cnt", perf_wr_cnt, exp_pwr);
    chk("perf_full_cnt", perf_full_cnt, exp_pfull);
    if (rst) begin
      model_reset();
    end else begin
      complete = m_busy && (!m_aw || bus.awready) && (!m_w || bus.wready);
      beff = bus.bvalid && (m_out > 0);
      m_done = '0; m_err = '0;
      if (beff && bus.bid < NR) begin
        m_done[bus.bid[1:0]] = 1'b1;
        m_err[bus.bid[1:0]] = (bus.bresp != 2'b00);
      end
      if (!m_busy && bus.req_valid != '0 && m_out == MAXO) m_full++;
      if (complete) m_wr++;
      m_out = m_out + int'(complete) - int'(beff);
      if (g >= 0) begin
        m_busy = 1; m_aw = 1; m_w = 1; m_id = g; m_last = g;
        m_addr = bus.req_addr[g*AW +: AW];
        m_data = bus.req_data[g*DW +: DW];
      end else if (m_busy) begin
        if (complete) m_busy = 0;
        m_aw = m_aw && !bus.awready;
        m_w = m_w && !bus.wready;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    cycle();
    rst = 0;
    grants.delete();
    n_aw_hs = 0; n_w_hs = 0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_aw_hs = 0; n_w_hs = 0;
    clk = 0; rst = 1;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;

    chk("rst_valids", {bus.awvalid, bus.wvalid}, 2'b00);
    chk("rst_done_err", {bus.req_done, bus.req_err}, 8'h00);
    chk("rst_awaddr", bus.awaddr, 0);
    chk("rst_awid", bus.awid, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_perf", {perf_wr_cnt, perf_full_cnt}, 64'd0);
    chk("const_fields", {bus.awlen, bus.awsize, bus.wstrb, bus.wlast, bus.bready},
        {8'h00, 3'b110, 8'hff, 1'b1, 1'b1});
    rst = 0;

    // Round-robin with all requesters held; B with out-of-range bid keeps credits free.
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[i*AW +: AW] = 32'h100 * (i + 1);
      bus.req_data[i*DW +: DW] = 64'hA5A5_0000_0000_0000 | 64'(i);
    end
    bus.req_valid = 4'hf; bus.awready = 1; bus.wready = 1;
    bus.bvalid = 1; bus.bid = 16'd7;
    repeat (9) cycle();
    chk("rr_grant_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", grants[i], i % NR);

    // Single requester 2; W completes a cycle ahead of AW.
    do_reset();
    bus.req_valid = 4'b0100;
    bus.req_addr[2*AW +: AW] = 32'h1000;
    bus.req_data[2*DW +: DW] = 64'hDEAD_BEEF_0000_1000;
    cycle();
    chk("single_grant", last_ready, 4'b0100);
    bus.req_valid = '0; bus.wready = 1;
    cycle();
    chk("aw_hold_after_w", {bus.awvalid, bus.wvalid}, 2'b10);
    chk("awaddr_1000", bus.awaddr, 32'h1000);
    bus.wready = 0; bus.awready = 1;
    cycle();
    chk("both_done", {bus.awvalid, bus.wvalid}, 2'b00);
    chk("aw_hs_count", n_aw_hs, 1);
    chk("w_hs_count", n_w_hs, 1);
    bus.req_valid = 4'b0001;
    cycle();
    chk("idle_regrant", last_ready, 4'b0001);

    // Outstanding limit of 2: third request stalls until a B frees a credit.
    do_reset();
    bus.req_valid = 4'b0111; bus.awready = 1; bus.wready = 1;
    repeat (4) cycle();
    chk("two_issued", grants.size(), 2);
    repeat (2) cycle();
    chk("full_stall", last_ready, 4'b0000);
    bus.bvalid = 1; bus.bid = 16'd1; bus.bresp = 2'b00;
    cycle();
    chk("stall_during_b", last_ready, 4'b0000);
    bus.bvalid = 0;
    chk("done1_pulse", bus.req_done, 4'b0010);
    cycle();
    chk("resume_grant", last_ready, 4'b0100);
    bus.req_valid = '0;
    cycle();

    // Error response pulse, then B with no credits outstanding.
    bus.bvalid = 1; bus.bid = 16'd3; bus.bresp = 2'b10;
    cycle();
    bus.bvalid = 0;
    chk("done_err3", {bus.req_done, bus.req_err}, 8'b1000_1000);
    cycle();
    chk("done_err3_one_cycle", {bus.req_done, bus.req_err}, 8'h00);
    bus.bvalid = 1; bus.bid = 16'd0; bus.bresp = 2'b00;
    cycle();
    bus.bvalid = 0;
    cycle();
    bus.bvalid = 1; bus.bid = 16'd2;
    cycle();
    bus.bvalid = 0;
    chk("b_at_zero_no_pulse", {bus.req_done, bus.req_err}, 8'h00);
    grants.delete();
    bus.req_valid = 4'b0001;
    repeat (4) cycle();
    bus.req_valid = '0;
    chk("no_underflow_grants", grants.size(), 2);
`ifdef RR_PCIM_ARB_PERF_EN
    chk("perf_wr_5", perf_wr_cnt, 5);
    chk("perf_full_3", perf_full_cnt, 3);
`else
    chk("perf_wr_off", perf_wr_cnt, 0);
    chk("perf_full_off", perf_full_cnt, 0);
`endif

    // Reset while AW is stalled abandons it and restarts priority at requester 0.
    do_reset();
    bus.req_valid = 4'b0100;
    cycle();
    bus.req_valid = '0;
    chk("pre_rst_awvalid", bus.awvalid, 1);
    rst = 1;
    cycle();
    rst = 0;
    chk("rst_abandon", {bus.awvalid, bus.wvalid}, 2'b00);
    bus.req_valid = 4'hf; bus.awready = 1; bus.wready = 1;
    cycle();
    chk("first_after_rst", last_ready, 4'b0001);

    // Randomized traffic against the model.
    do_reset();
    repeat (600) begin
      bus.req_valid = NR'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) begin
        bus.req_addr[i*AW +: AW] = $urandom;
        bus.req_data[i*DW +: DW] = {$urandom, $urandom};
      end
      bus.awready = ($urandom_range(0, 3) != 0);
      bus.wready = ($urandom_range(0, 3) != 0);
      bus.bvalid = ($urandom_range(0, 2) == 0);
      bus.bid = 16'($urandom_range(0, 5));
      bus.bresp = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
